// File: rtl/traffic_queue_sensor.sv
// traffic_queue_sensor: per-street car queues feeding the controller's sensor input, plus a light-sequence safety monitor
module traffic_queue_sensor #(
  parameter int QW = 4,
  parameter int DEPART_CYC = 2
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          arrive_a,
  input  logic          arrive_b,
  input  logic [1:0]    sa,
  input  logic [1:0]    sb,
  output logic [1:0]    t,
  output logic [QW-1:0] qa_cnt,
  output logic [QW-1:0] qb_cnt,
  output logic          dep_a,
  output logic          dep_b,
  output logic [1:0]    ovf,
  output logic [2:0]    err
);
  localparam int TW = DEPART_CYC > 1 ? $clog2(DEPART_CYC) : 1;
  logic [1:0][1:0]    code;
  logic [1:0][QW-1:0] q;
  logic [1:0][TW-1:0] tmr;
  logic [1:0]         arr, busy, go, full, dep;
  logic [1:0]         prev_sa, prev_sb;
  assign code = {sb, sa};
  assign arr = {arrive_b, arrive_a};
  for (genvar s = 0; s < 2; s++) begin : g_st
    assign busy[s] = code[s] == 2'b10 && q[s] != '0;
    assign go[s] = busy[s] && tmr[s] == TW'(DEPART_CYC - 1);
    assign full[s] = &q[s];
  end
  // t depends only on registered counts, never on the light inputs
  assign t = {q[0] == '0, q[1] != '0};
  assign qa_cnt = q[0];
  assign qb_cnt = q[1];
  assign dep_a = dep[0];
  assign dep_b = dep[1];
  always_ff @(posedge clk) begin
    if (reset) begin
      q <= '0;
      tmr <= '0;
      dep <= '0;
      ovf <= '0;
      err <= '0;
      prev_sa <= 2'b00;
      prev_sb <= 2'b00;
    end else begin
      for (int i = 0; i < 2; i++) begin
        tmr[i] <= busy[i] && !go[i] ? tmr[i] + TW'(1) : '0;
        dep[i] <= go[i];
        if (arr[i] && !go[i] && !full[i]) q[i] <= q[i] + QW'(1);
        else if (!arr[i] && go[i]) q[i] <= q[i] - QW'(1);
        if (arr[i] && !go[i] && full[i]) ovf[i] <= 1'b1;
      end
      err <= err | {(prev_sa == 2'b10 && sa == 2'b00) || (prev_sb == 2'b10 && sb == 2'b00),
                    sa != 2'b00 && sb != 2'b00,
                    sa == 2'b11 || sb == 2'b11};
      prev_sa <= sa;
      prev_sb <= sb;
    end
  end
endmodule

// File: tb/tb_traffic_queue_sensor.sv
// tb_traffic_queue_sensor: directed vectors plus hand sequences for the queue sensor
module tb_traffic_queue_sensor;
  logic       clk = 1'b0, reset = 1'b0;
  logic       aa = 1'b0, ab = 1'b0;
  logic [1:0] sa = 2'b00, sb = 2'b00;
  logic [1:0] t, ovf;
  logic [3:0] qa, qb;
  logic       da, db;
  logic [2:0] err;
  logic       a2 = 1'b0, b2 = 1'b0;
  logic [1:0] sa2 = 2'b00, sb2 = 2'b00;
  logic [1:0] t2, ovf2;
  logic [1:0] qa2, qb2;
  logic       da2, db2;
  logic [2:0] err2;
  int tests = 0, fails = 0;

  traffic_queue_sensor #(.QW(4), .DEPART_CYC(2)) dut (
    .clk(clk), .reset(reset), .arrive_a(aa), .arrive_b(ab), .sa(sa), .sb(sb),
    .t(t), .qa_cnt(qa), .qb_cnt(qb), .dep_a(da), .dep_b(db), .ovf(ovf), .err(err));
  traffic_queue_sensor #(.QW(2), .DEPART_CYC(2)) dut2 (
    .clk(clk), .reset(reset), .arrive_a(a2), .arrive_b(b2), .sa(sa2), .sb(sb2),
    .t(t2), .qa_cnt(qa2), .qb_cnt(qb2), .dep_a(da2), .dep_b(db2), .ovf(ovf2), .err(err2));

  always #5 clk = ~clk;

  typedef struct {
    logic aa, ab;
    logic [1:0] sa, sb, t;
    logic [3:0] qa, qb;
    logic da, db;
    logic [2:0] err;
  } vec_t;
  vec_t tbl[$];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    reset = 1'b0;
  endtask

  initial begin
    // test 2: A green, three arrivals, drain at one car per two edges
    tbl.push_back('{1, 0, 2'b10, 2'b00, 2'b00, 1, 0, 0, 0, 0});
    tbl.push_back('{1, 0, 2'b10, 2'b00, 2'b00, 2, 0, 0, 0, 0});
    tbl.push_back('{1, 0, 2'b10, 2'b00, 2'b00, 2, 0, 1, 0, 0});
    tbl.push_back('{0, 0, 2'b10, 2'b00, 2'b00, 2, 0, 0, 0, 0});
    tbl.push_back('{0, 0, 2'b10, 2'b00, 2'b00, 1, 0, 1, 0, 0});
    tbl.push_back('{0, 0, 2'b10, 2'b00, 2'b00, 1, 0, 0, 0, 0});
    tbl.push_back('{0, 0, 2'b10, 2'b00, 2'b10, 0, 0, 1, 0, 0});
    tbl.push_back('{0, 0, 2'b10, 2'b00, 2'b10, 0, 0, 0, 0, 0});
    tbl.push_back('{0, 0, 2'b01, 2'b00, 2'b10, 0, 0, 0, 0, 0});
    tbl.push_back('{0, 0, 2'b00, 2'b00, 2'b10, 0, 0, 0, 0, 0});
    // test 3: five B arrivals on red
    for (int k = 1; k <= 5; k++)
      tbl.push_back('{0, 1, 2'b00, 2'b00, 2'b11, 0, 4'(k), 0, 0, 0});
    // B green one edge, yellow restarts the timer, then drain
    tbl.push_back('{0, 0, 2'b00, 2'b10, 2'b11, 0, 5, 0, 0, 0});
    tbl.push_back('{0, 0, 2'b00, 2'b01, 2'b11, 0, 5, 0, 0, 0});
    tbl.push_back('{0, 0, 2'b00, 2'b10, 2'b11, 0, 5, 0, 0, 0});
    for (int k = 4; k >= 0; k--) begin
      tbl.push_back('{0, 0, 2'b00, 2'b10, k > 0 ? 2'b11 : 2'b10, 0, 4'(k), 0, 1, 0});
      if (k > 0) tbl.push_back('{0, 0, 2'b00, 2'b10, 2'b11, 0, 4'(k), 0, 0, 0});
    end

    // test 1: reset state
    sa = 2'b10;
    do_reset();
    chk("reset_t", t, 2);
    chk("reset_qa", qa, 0);
    chk("reset_qb", qb, 0);
    chk("reset_dep", {da, db}, 0);
    chk("reset_err", err, 0);
    chk("reset_ovf", ovf, 0);
    step();
    chk("idle_t", t, 2);
    chk("idle_dep", {da, db}, 0);

    foreach (tbl[i]) begin
      aa = tbl[i].aa; ab = tbl[i].ab; sa = tbl[i].sa; sb = tbl[i].sb;
      step();
      chk($sformatf("row%0d_t", i), t, tbl[i].t);
      chk($sformatf("row%0d_qa", i), qa, tbl[i].qa);
      chk($sformatf("row%0d_qb", i), qb, tbl[i].qb);
      chk($sformatf("row%0d_dep_a", i), da, tbl[i].da);
      chk($sformatf("row%0d_dep_b", i), db, tbl[i].db);
      chk($sformatf("row%0d_err", i), err, tbl[i].err);
    end
    aa = 0; ab = 0;

    // test 4: QW=2 overflow and arrival coinciding with departure
    sa = 2'b00; sb = 2'b00;
    do_reset();
    a2 = 1'b1;
    repeat (3) step();
    chk("q2_fill_qa", qa2, 3);
    chk("q2_fill_ovf", ovf2, 0);
    step();
    chk("q2_drop_qa", qa2, 3);
    chk("q2_drop_ovf", ovf2, 1);
    sa2 = 2'b10;
    step();
    chk("q2_green1_qa", qa2, 3);
    step();
    chk("q2_dep_qa", qa2, 3);
    chk("q2_dep_pulse", da2, 1);
    chk("q2_err", err2, 0);
    a2 = 1'b0; sa2 = 2'b00;

    // test 5: light sequence monitor
    sa = 2'b10; sb = 2'b00;
    do_reset();
    step();
    sa = 2'b01; step();
    sa = 2'b00; step();
    chk("seq_legal_err", err, 0);
    sa = 2'b10; step();
    sa = 2'b00; step();
    chk("seq_skip_a_err", err, 4);
    sa = 2'b10; sb = 2'b01; step();
    chk("seq_both_err", err, 6);
    sa = 2'b00; sb = 2'b11; step();
    chk("seq_ill_err", err, 7);
    sb = 2'b00; step();
    chk("seq_sticky_err", err, 7);
    sa = 2'b00; sb = 2'b10;
    do_reset();
    chk("seq_reset_err", err, 0);
    step();
    sb = 2'b00; step();
    chk("seq_skip_b_err", err, 4);

    // test 6: reset mid-departure
    sa = 2'b00; sb = 2'b00;
    do_reset();
    aa = 1'b1;
    repeat (5) step();
    aa = 1'b0; sa = 2'b10;
    step();
    chk("mid_pre_qa", qa, 5);
    aa = 1'b1; ab = 1'b1; sb = 2'b11;
    do_reset();
    chk("mid_qa", qa, 0);
    chk("mid_qb", qb, 0);
    chk("mid_dep", {da, db}, 0);
    chk("mid_err", err, 0);
    chk("mid_ovf", ovf, 0);
    chk("mid_t", t, 2);
    aa = 1'b0; ab = 1'b0; sa = 2'b00; sb = 2'b00;
    step();
    chk("mid_after_err", err, 0);
    chk("mid_after_dep", da, 0);

    // test 7: legal light cycle with random arrivals, then drain
    do_reset();
    for (int r = 0; r < 120; r++) begin
      for (int c = 0; c < 22; c++) begin
        sa = c < 8 ? 2'b10 : c < 10 ? 2'b01 : 2'b00;
        sb = c >= 11 && c < 19 ? 2'b10 : c >= 19 && c < 21 ? 2'b01 : 2'b00;
        aa = r < 100 && $urandom_range(0, 7) == 0;
        ab = r < 100 && $urandom_range(0, 7) == 0;
        step();
      end
      if (r >= 100 && qa == 0 && qb == 0) break;
    end
    chk("loop_qa_drained", qa, 0);
    chk("loop_qb_drained", qb, 0);
    chk("loop_err", err, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
